// File: rtl/period_detector_5bit.sv
// Period detector for the ADPLL control path.
// Measures reference and DCO periods in clk cycles and turns their difference
// into a saturated sign/magnitude correction with a valid strobe and a lock flag.
module period_detector_5bit #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_TOL   = 1,
  parameter int unsigned LOCK_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ref_in,
  input  logic       dco_in,
  output logic       ctrl_sign,
  output logic [4:0] ctrl,
  output logic       ctrl_valid,
  output logic       locked
);

  // Channel 0 is the reference, channel 1 is the DCO.
  localparam int unsigned NCH = 2;
  localparam int unsigned LW  = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   TOL      = LOCK_TOL[CNT_W:0];
  localparam logic [CNT_W:0]   CTRL_SAT = 31;
  localparam logic [LW-1:0]    LOCK_TGT = LOCK_COUNT[LW-1:0];

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] prev;
  logic [NCH-1:0] edge_hit;
  logic [NCH-1:0] armed;
  logic [NCH-1:0] fresh;

  logic [CNT_W-1:0] count  [NCH];
  logic [CNT_W-1:0] period [NCH];

  logic              update;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]    mag;
  logic [4:0]        ctrl_next;
  logic              sign_next;
  logic              in_lock;

  state_t            state;
  state_t            state_next;
  logic [LW-1:0]     lock_cnt;
  logic [LW-1:0]     lock_cnt_next;

  assign raw      = {dco_in, ref_in};
  assign edge_hit = sync2 & ~prev;

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  // These keep running while disabled so re-enable sees clean history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // An update fires once both channels hold an unconsumed period.
  assign update = enable & fresh[0] & fresh[1];

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    // Per-channel saturating period counter, arming and capture.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count[ch]  <= '0;
        period[ch] <= '0;
        armed[ch]  <= 1'b0;
        fresh[ch]  <= 1'b0;
      end else if (!enable) begin
        count[ch] <= '0;
        armed[ch] <= 1'b0;
        fresh[ch] <= 1'b0;
      end else if (edge_hit[ch]) begin
        count[ch] <= '0;
        if (armed[ch]) begin
          period[ch] <= (count[ch] == CNT_MAX) ? CNT_MAX : count[ch] + CNT_W'(1);
          fresh[ch]  <= 1'b1;
        end else begin
          armed[ch] <= 1'b1;
        end
      end else begin
        if (count[ch] != CNT_MAX) begin
          count[ch] <= count[ch] + CNT_W'(1);
        end
        if (update) begin
          fresh[ch] <= 1'b0;
        end
      end
    end
  end

  // Signed difference, magnitude and saturated correction.
  always_comb begin
    diff      = $signed({1'b0, period[0]}) - $signed({1'b0, period[1]});
    mag       = diff[CNT_W] ? (~diff + 1'b1) : diff;
    ctrl_next = (mag > CTRL_SAT) ? 5'd31 : mag[4:0];
    sign_next = ~diff[CNT_W] & (|diff);
    in_lock   = (mag <= TOL);
  end

  // Correction output register; ctrl/ctrl_sign hold between updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_sign  <= 1'b0;
      ctrl       <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= update;
      if (update) begin
        ctrl_sign <= sign_next;
        ctrl      <= ctrl_next;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Lock next-state: counts consecutive in-tolerance updates.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    if (!enable) begin
      state_next    = UNLOCKED;
      lock_cnt_next = '0;
    end else if (update) begin
      if (in_lock) begin
        lock_cnt_next = (lock_cnt >= LOCK_TGT) ? LOCK_TGT : lock_cnt + LW'(1);
        if (lock_cnt_next == LOCK_TGT) begin
          state_next = LOCKED;
        end
      end else begin
        lock_cnt_next = '0;
        state_next    = UNLOCKED;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_period_detector_5bit.sv
// Directed bench for period_detector_5bit with an event-level reference model.
module tb_period_detector_5bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       ref_in = 1'b0;
  logic       dco_in = 1'b0;
  logic       ctrl_sign;
  logic [4:0] ctrl;
  logic       ctrl_valid;
  logic       locked;

  int checks = 0;
  int errors = 0;

  period_detector_5bit #(.CNT_W(16), .LOCK_TOL(1), .LOCK_COUNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ref_in(ref_in), .dco_in(dco_in),
    .ctrl_sign(ctrl_sign), .ctrl(ctrl), .ctrl_valid(ctrl_valid), .locked(locked)
  );

  initial forever #5 clk = ~clk;

  // Input waveform generators: period in clk cycles, 0 = hold level.
  int unsigned ref_per = 0, dco_per = 0;
  int unsigned ref_ph = 0, dco_ph = 0;
  bit dco_hold = 0, stall_req = 0;

  initial forever begin
    @(negedge clk);
    if (ref_per != 0) begin
      ref_ph = (ref_ph + 1) % ref_per;
      ref_in = (ref_ph < ref_per / 2);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!dco_hold && dco_per != 0) begin
      dco_ph = (dco_ph + 1) % dco_per;
      dco_in = (dco_ph < dco_per / 2);
      if (stall_req && dco_ph == 0) begin
        dco_hold  = 1;
        stall_req = 0;
      end
    end
  end

  // Reference model: edges are seen two samples after the input is first
  // sampled high; periods are timestamp differences capped at 65535.
  int unsigned cyc = 0;
  bit [2:0] hist [2];
  bit       m_armed [2];
  bit       m_fresh [2];
  int       m_last [2];
  int       m_per [2];
  int       m_lockcnt = 0;
  bit       e_sign = 0, e_valid = 0, e_locked = 0;
  int       e_ctrl = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        hist[i] = '0; m_armed[i] = 0; m_fresh[i] = 0; m_last[i] = 0; m_per[i] = 0;
      end
      m_lockcnt = 0; e_sign = 0; e_valid = 0; e_locked = 0; e_ctrl = 0;
    end else begin
      bit ev [2];
      bit smp [2];
      cyc++;
      smp[0] = ref_in;
      smp[1] = dco_in;
      for (int i = 0; i < 2; i++) begin
        ev[i]   = hist[i][1] & ~hist[i][2];
        hist[i] = {hist[i][1:0], smp[i]};
      end
      if (!enable) begin
        for (int i = 0; i < 2; i++) begin m_armed[i] = 0; m_fresh[i] = 0; end
        m_lockcnt = 0; e_locked = 0; e_valid = 0;
      end else begin
        e_valid = 0;
        if (m_fresh[0] && m_fresh[1]) begin
          int d, a;
          d = m_per[0] - m_per[1];
          a = (d < 0) ? -d : d;
          e_valid = 1;
          e_sign  = (d > 0);
          e_ctrl  = (a > 31) ? 31 : a;
          if (a <= 1) begin
            m_lockcnt = (m_lockcnt + 1 > 8) ? 8 : m_lockcnt + 1;
            if (m_lockcnt == 8) e_locked = 1;
          end else begin
            m_lockcnt = 0;
            e_locked  = 0;
          end
          m_fresh[0] = 0;
          m_fresh[1] = 0;
        end
        for (int i = 0; i < 2; i++) begin
          if (ev[i]) begin
            if (m_armed[i]) begin
              m_per[i]   = (int'(cyc) - m_last[i] > 65535) ? 65535 : int'(cyc) - m_last[i];
              m_fresh[i] = 1;
            end else begin
              m_armed[i] = 1;
            end
            m_last[i] = int'(cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ctrl_valid", int'(ctrl_valid), int'(e_valid));
      check("ctrl_sign", int'(ctrl_sign), int'(e_sign));
      check("ctrl", int'(ctrl), e_ctrl);
      check("locked", int'(locked), int'(e_locked));
    end
  end

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ctrl_valid && n < budget);
    check("wait_valid_timeout", int'(ctrl_valid), 1);
  endtask

  task automatic wait_valids(input int cnt, input int budget);
    for (int i = 0; i < cnt; i++) wait_valid(budget);
  endtask

  initial begin
    int n;
    int vcount;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("rst_ctrl", int'(ctrl), 0);
    check("rst_sign", int'(ctrl_sign), 0);
    check("rst_valid", int'(ctrl_valid), 0);
    check("rst_locked", int'(locked), 0);
    @(posedge clk); #3 rst_n = 1;

    // 20 vs 16: DCO too fast -> sign 1, magnitude 4, one-cycle pulses.
    @(negedge clk);
    enable = 1; ref_per = 20; dco_per = 16;
    for (int i = 0; i < 3; i++) begin
      wait_valid(100);
      check("a_ctrl", int'(ctrl), 4);
      check("a_sign", int'(ctrl_sign), 1);
      check("a_model_ctrl", e_ctrl, 4);
      check("a_locked", int'(locked), 0);
      @(negedge clk);
      check("a_pulse_width", int'(ctrl_valid), 0);
    end

    // 20 vs 60: saturated magnitude, no lock.
    dco_per = 60;
    wait_valids(2, 200);
    wait_valid(200);
    check("b_ctrl", int'(ctrl), 31);
    check("b_sign", int'(ctrl_sign), 0);
    check("b_locked", int'(locked), 0);

    // 20 vs 21: in tolerance, lock after eight updates.
    dco_per = 21;
    wait_valids(12, 100);
    check("c_ctrl", int'(ctrl), 1);
    check("c_sign", int'(ctrl_sign), 0);
    check("c_locked", int'(locked), 1);
    check("c_model_locked", int'(e_locked), 1);

    // 20 vs 25: out of tolerance drops lock.
    dco_per = 25;
    wait_valids(2, 100);
    check("c2_ctrl", int'(ctrl), 5);
    check("c2_sign", int'(ctrl_sign), 0);
    check("c2_locked", int'(locked), 0);

    // Relock, then stall the DCO for longer than the counter range.
    dco_per = 21;
    wait_valids(12, 100);
    check("d_locked_pre", int'(locked), 1);
    @(posedge clk); stall_req = 1;
    n = 0;
    while (!dco_hold && n < 100) begin @(posedge clk); n++; end
    check("d_stall_started", int'(dco_hold), 1);
    vcount = 0;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      if (i >= 10 && ctrl_valid) vcount++;
    end
    check("d_stall_no_valid", vcount, 0);
    check("d_stall_locked_hold", int'(locked), 1);
    check("d_stall_ctrl_hold", int'(ctrl), 1);
    @(posedge clk); dco_hold = 0;
    wait_valid(200);
    check("d_sat_ctrl", int'(ctrl), 31);
    check("d_sat_sign", int'(ctrl_sign), 0);
    check("d_sat_locked", int'(locked), 0);

    // Enable drop mid-period.
    wait_valids(12, 100);
    check("e_locked_pre", int'(locked), 1);
    repeat (5) @(negedge clk);
    enable = 0;
    @(negedge clk);
    check("e_locked_drop", int'(locked), 0);
    check("e_ctrl_hold", int'(ctrl), 1);
    check("e_valid_low", int'(ctrl_valid), 0);
    repeat (4) @(negedge clk);
    enable = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ctrl_valid && n < 200);
    check("e_reenable_valid", int'(ctrl_valid), 1);
    check("e_reenable_delay_ge_21", int'(n >= 21), 1);
    check("e_reenable_ctrl", int'(ctrl), 1);

    // Asynchronous reset between clock edges.
    @(posedge clk); #3 rst_n = 0;
    #1;
    check("f_rst_ctrl", int'(ctrl), 0);
    check("f_rst_sign", int'(ctrl_sign), 0);
    check("f_rst_valid", int'(ctrl_valid), 0);
    check("f_rst_locked", int'(locked), 0);
    dco_per = 16;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    wait_valid(120);
    check("f_ctrl", int'(ctrl), 4);
    check("f_sign", int'(ctrl_sign), 1);
    check("f_locked", int'(locked), 0);
    wait_valids(2, 100);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
